// File: rtl/chu_spi_slv_pkg.sv
// Shared constants for the FPro SPI responder slot: register map,
// status/control bit positions and the frame state encoding.
package chu_spi_slv_pkg;

    localparam logic [4:0] REG_STATUS  = 5'd0;
    localparam logic [4:0] REG_TX_DATA = 5'd1;
    localparam logic [4:0] REG_CLEAR   = 5'd2;
    localparam logic [4:0] REG_CTRL    = 5'd3;
    localparam logic [4:0] REG_OVR_CNT = 5'd4;

    localparam int CLR_RX_VALID_BIT = 0;
    localparam int CLR_OVERRUN_BIT  = 1;
    localparam int CTRL_CPOL_BIT    = 0;
    localparam int CTRL_CPHA_BIT    = 1;

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_t;

endpackage

// File: rtl/chu_spi_slv_sync.sv
// Brings the asynchronous SPI pins into the clk domain and produces
// single-cycle edge pulses for sclk and ss_n from the synchronized copies.
module chu_spi_slv_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic spi_sclk,
    input  logic spi_mosi,
    input  logic spi_ss_n,
    output logic mosi_s,
    output logic sclk_rise,
    output logic sclk_fall,
    output logic ss_fall,
    output logic ss_rise
);

    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic [SYNC_STAGES-1:0] ss_sync_q, ss_sync_d;
    logic                   sclk_prev_q, sclk_prev_d;
    logic                   ss_prev_q, ss_prev_d;

    // Shift each pin one stage deeper and remember the last synced level.
    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
        ss_sync_d   = {ss_sync_q[SYNC_STAGES-2:0], spi_ss_n};
        sclk_prev_d = sclk_sync_q[SYNC_STAGES-1];
        ss_prev_d   = ss_sync_q[SYNC_STAGES-1];
    end

    // ss_n chain clears to 0 so a select already held low across reset
    // never looks like a fresh fall; the master must deselect first.
    always_ff @(posedge clk) begin
        if (reset) begin
            sclk_sync_q <= '0;
            mosi_sync_q <= '0;
            ss_sync_q   <= '0;
            sclk_prev_q <= 1'b0;
            ss_prev_q   <= 1'b0;
        end else begin
            sclk_sync_q <= sclk_sync_d;
            mosi_sync_q <= mosi_sync_d;
            ss_sync_q   <= ss_sync_d;
            sclk_prev_q <= sclk_prev_d;
            ss_prev_q   <= ss_prev_d;
        end
    end

    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign sclk_rise =  sclk_sync_q[SYNC_STAGES-1] & ~sclk_prev_q;
    assign sclk_fall = ~sclk_sync_q[SYNC_STAGES-1] &  sclk_prev_q;
    assign ss_rise   =  ss_sync_q[SYNC_STAGES-1]   & ~ss_prev_q;
    assign ss_fall   = ~ss_sync_q[SYNC_STAGES-1]   &  ss_prev_q;

endmodule

// File: rtl/chu_spi_slave_core.sv
// FPro MMIO slot acting as an SPI responder, oversampled in the clk domain.
// Optional feature: define SPI_SLV_OVR_CNT_EN to add a saturating overrun
// counter readable at register 4 (cleared together with the overrun flag).
module chu_spi_slave_core
    import chu_spi_slv_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] IDLE_BYTE   = 8'hFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cs,
    input  logic        read,
    input  logic        write,
    input  logic [4:0]  addr,
    output logic [31:0] rd_data,
    input  logic [31:0] wr_data,
    input  logic        spi_sclk,
    input  logic        spi_mosi,
    input  logic        spi_ss_n,
    output logic        spi_miso,
    output logic        spi_miso_oe
);

    logic mosi_s, sclk_rise, sclk_fall, ss_fall, ss_rise;

    chu_spi_slv_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk       (clk),
        .reset     (reset),
        .spi_sclk  (spi_sclk),
        .spi_mosi  (spi_mosi),
        .spi_ss_n  (spi_ss_n),
        .mosi_s    (mosi_s),
        .sclk_rise (sclk_rise),
        .sclk_fall (sclk_fall),
        .ss_fall   (ss_fall),
        .ss_rise   (ss_rise)
    );

    state_t     state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_out_q, shift_out_d;
    logic [6:0] shift_in_q, shift_in_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       overrun_q, overrun_d;
    logic [7:0] tx_buf_q, tx_buf_d;
    logic       tx_empty_q, tx_empty_d;
    logic [1:0] ctrl_q, ctrl_d;
    logic       frame_cpol_q, frame_cpol_d;
    logic       frame_cpha_q, frame_cpha_d;
    logic       miso_q, miso_d;
    logic       miso_oe_q, miso_oe_d;
`ifdef SPI_SLV_OVR_CNT_EN
    logic [7:0] ovr_cnt_q, ovr_cnt_d;
`endif

    logic       wr_en, clr_rx, clr_ovr, tx_write, ctrl_write;
    logic       leading_ev, trailing_ev, sample_ev, shift_ev;
    logic [7:0] load_byte, rx_byte;
    logic       unused_inputs;

    assign wr_en       = cs & write;
    assign clr_rx      = wr_en && (addr == REG_CLEAR) && wr_data[CLR_RX_VALID_BIT];
    assign clr_ovr     = wr_en && (addr == REG_CLEAR) && wr_data[CLR_OVERRUN_BIT];
    assign tx_write    = wr_en && (addr == REG_TX_DATA);
    assign ctrl_write  = wr_en && (addr == REG_CTRL);
    assign leading_ev  = frame_cpol_q ? sclk_fall : sclk_rise;
    assign trailing_ev = frame_cpol_q ? sclk_rise : sclk_fall;
    assign sample_ev   = frame_cpha_q ? trailing_ev : leading_ev;
    assign shift_ev    = frame_cpha_q ? leading_ev : trailing_ev;
    assign load_byte   = tx_empty_q ? IDLE_BYTE : tx_buf_q;
    assign rx_byte     = {shift_in_q, mosi_s};
    assign unused_inputs = ^{read, wr_data[31:8]};

    // Frame FSM plus register side effects; clears apply before a byte lands
    // and a CPU TX write wins over a same-cycle buffer consumption.
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_out_d  = shift_out_q;
        shift_in_d   = shift_in_q;
        rx_data_d    = rx_data_q;
        rx_valid_d   = rx_valid_q;
        overrun_d    = overrun_q;
        tx_buf_d     = tx_buf_q;
        tx_empty_d   = tx_empty_q;
        ctrl_d       = ctrl_q;
        frame_cpol_d = frame_cpol_q;
        frame_cpha_d = frame_cpha_q;
        miso_d       = miso_q;
        miso_oe_d    = miso_oe_q;
`ifdef SPI_SLV_OVR_CNT_EN
        ovr_cnt_d    = ovr_cnt_q;
`endif

        if (clr_rx) rx_valid_d = 1'b0;
        if (clr_ovr) begin
            overrun_d = 1'b0;
`ifdef SPI_SLV_OVR_CNT_EN
            ovr_cnt_d = 8'd0;
`endif
        end
        if (ctrl_write) ctrl_d = wr_data[1:0];

        case (state_q)
            IDLE: begin
                if (ss_fall) begin
                    state_d      = ACTIVE;
                    frame_cpol_d = ctrl_q[CTRL_CPOL_BIT];
                    frame_cpha_d = ctrl_q[CTRL_CPHA_BIT];
                    bit_cnt_d    = 3'd0;
                    shift_out_d  = load_byte;
                    miso_d       = load_byte[7];
                    tx_empty_d   = 1'b1;
                    miso_oe_d    = 1'b1;
                end
            end
            ACTIVE: begin
                if (ss_rise) begin
                    state_d   = IDLE;
                    bit_cnt_d = 3'd0;
                    miso_d    = 1'b0;
                    miso_oe_d = 1'b0;
                end else if (sample_ev) begin
                    shift_in_d = rx_byte[6:0];
                    bit_cnt_d  = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        if (rx_valid_d) begin
                            overrun_d = 1'b1;
`ifdef SPI_SLV_OVR_CNT_EN
                            if (ovr_cnt_q != 8'hFF) ovr_cnt_d = ovr_cnt_q + 8'd1;
`endif
                        end else begin
                            rx_data_d  = rx_byte;
                            rx_valid_d = 1'b1;
                        end
                        shift_out_d = load_byte;
                        tx_empty_d  = 1'b1;
                        if (!frame_cpha_q) miso_d = load_byte[7];
                    end
                end else if (shift_ev) begin
                    if (frame_cpha_q) begin
                        miso_d      = shift_out_q[7];
                        shift_out_d = {shift_out_q[6:0], 1'b0};
                    end else if (bit_cnt_q != 3'd0) begin
                        miso_d      = shift_out_q[6];
                        shift_out_d = {shift_out_q[6:0], 1'b0};
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (tx_write) begin
            tx_buf_d   = wr_data[7:0];
            tx_empty_d = 1'b0;
        end
    end

    // State and register storage with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            bit_cnt_q    <= 3'd0;
            shift_out_q  <= 8'd0;
            shift_in_q   <= 7'd0;
            rx_data_q    <= 8'd0;
            rx_valid_q   <= 1'b0;
            overrun_q    <= 1'b0;
            tx_buf_q     <= 8'd0;
            tx_empty_q   <= 1'b1;
            ctrl_q       <= 2'd0;
            frame_cpol_q <= 1'b0;
            frame_cpha_q <= 1'b0;
            miso_q       <= 1'b0;
            miso_oe_q    <= 1'b0;
`ifdef SPI_SLV_OVR_CNT_EN
            ovr_cnt_q    <= 8'd0;
`endif
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_out_q  <= shift_out_d;
            shift_in_q   <= shift_in_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            overrun_q    <= overrun_d;
            tx_buf_q     <= tx_buf_d;
            tx_empty_q   <= tx_empty_d;
            ctrl_q       <= ctrl_d;
            frame_cpol_q <= frame_cpol_d;
            frame_cpha_q <= frame_cpha_d;
            miso_q       <= miso_d;
            miso_oe_q    <= miso_oe_d;
`ifdef SPI_SLV_OVR_CNT_EN
            ovr_cnt_q    <= ovr_cnt_d;
`endif
        end
    end

    // Register read mux, combinational from addr.
    always_comb begin
        rd_data = 32'd0;
        case (addr)
            REG_STATUS: rd_data = {20'd0, (state_q == ACTIVE), tx_empty_q,
                                   overrun_q, rx_valid_q, rx_data_q};
            REG_CTRL:   rd_data = {30'd0, ctrl_q};
`ifdef SPI_SLV_OVR_CNT_EN
            REG_OVR_CNT: rd_data = {24'd0, ovr_cnt_q};
`endif
            default:    rd_data = 32'd0;
        endcase
    end

    assign spi_miso    = miso_q;
    assign spi_miso_oe = miso_oe_q;

endmodule

// File: tb/tb_chu_spi_slave_core.sv
// Directed bench for chu_spi_slave_core: a behavioural SPI master drives
// frames in all four modes while the CPU side pokes the slot registers.
module tb_chu_spi_slave_core;

    logic        clk = 1'b0;
    logic        reset, cs, read, write;
    logic [4:0]  addr;
    logic [31:0] rd_data, wr_data;
    logic        spi_sclk, spi_mosi, spi_ss_n, spi_miso, spi_miso_oe;

    int testCount = 0;
    int failCount = 0;

    always #5 clk = ~clk;

    chu_spi_slave_core dut (
        .clk         (clk),
        .reset       (reset),
        .cs          (cs),
        .read        (read),
        .write       (write),
        .addr        (addr),
        .rd_data     (rd_data),
        .wr_data     (wr_data),
        .spi_sclk    (spi_sclk),
        .spi_mosi    (spi_mosi),
        .spi_ss_n    (spi_ss_n),
        .spi_miso    (spi_miso),
        .spi_miso_oe (spi_miso_oe)
    );

    // Count one comparison and report it if the observed value is wrong.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        testCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic mmioWrite(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        cs = 1'b1; write = 1'b1; addr = a; wr_data = d;
        @(negedge clk);
        cs = 1'b0; write = 1'b0; wr_data = 32'd0;
    endtask

    task automatic mmioRead(input logic [4:0] a, output logic [31:0] d);
        @(negedge clk);
        cs = 1'b1; read = 1'b1; addr = a;
        #1;
        d = rd_data;
        cs = 1'b0; read = 1'b0;
    endtask

    task automatic halfWait();
        repeat (8) @(negedge clk);
    endtask

    task automatic ssLow();
        spi_ss_n = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic ssHigh();
        halfWait();
        spi_ss_n = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    // Master shifts nbits MSB first; popAtLast pulses a reg2 bit0 write so
    // it lands on the cycle the core registers the 8th mode-0 sample.
    task automatic applyStimulus(input logic [7:0] txByte, input int nbits,
                                 input logic cpol, input logic cpha,
                                 input bit popAtLast, output logic [7:0] rxByte);
        rxByte = 8'd0;
        for (int i = 7; i > 7 - nbits; i--) begin
            if (!cpha) begin
                spi_mosi = txByte[i];
                halfWait();
                spi_sclk = ~cpol;
                rxByte[i] = spi_miso;
                if (popAtLast && i == 0) begin
                    @(negedge clk);
                    @(negedge clk);
                    cs = 1'b1; write = 1'b1; addr = 5'd2; wr_data = 32'd1;
                    @(negedge clk);
                    cs = 1'b0; write = 1'b0; wr_data = 32'd0;
                    repeat (5) @(negedge clk);
                end else begin
                    halfWait();
                end
                spi_sclk = cpol;
            end else begin
                halfWait();
                spi_sclk = ~cpol;
                spi_mosi = txByte[i];
                halfWait();
                spi_sclk = cpol;
                rxByte[i] = spi_miso;
            end
        end
    endtask

    logic [31:0] rdVal;
    logic [7:0]  rxA, rxB;
    logic [1:0]  modeBits;
    logic        cpol, cpha;

    initial begin
        reset = 1'b1; cs = 1'b0; read = 1'b0; write = 1'b0;
        addr = 5'd0; wr_data = 32'd0;
        spi_sclk = 1'b0; spi_mosi = 1'b0; spi_ss_n = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);

        // Reset state
        mmioRead(5'd0, rdVal); checkOutput("reset_status", rdVal, 32'h400);
        mmioRead(5'd3, rdVal); checkOutput("reset_ctrl", rdVal, 32'h0);
        mmioRead(5'd4, rdVal); checkOutput("reset_reg4", rdVal, 32'h0);
        mmioRead(5'd7, rdVal); checkOutput("unmapped_read", rdVal, 32'h0);
        checkOutput("reset_miso_oe", 32'(spi_miso_oe), 32'h0);
        checkOutput("reset_miso", 32'(spi_miso), 32'h0);

        // Mode 0 single byte
        mmioWrite(5'd1, 32'hA5);
        ssLow();
        checkOutput("mode0_oe_active", 32'(spi_miso_oe), 32'h1);
        mmioRead(5'd0, rdVal); checkOutput("mode0_status_active", rdVal, 32'hC00);
        applyStimulus(8'h3C, 8, 1'b0, 1'b0, 1'b0, rxA);
        ssHigh();
        checkOutput("mode0_miso_byte", 32'(rxA), 32'hA5);
        checkOutput("mode0_oe_idle", 32'(spi_miso_oe), 32'h0);
        mmioRead(5'd0, rdVal); checkOutput("mode0_status", rdVal, 32'h53C);
        mmioWrite(5'd2, 32'h1);
        mmioRead(5'd0, rdVal); checkOutput("mode0_pop", rdVal, 32'h43C);

        // Modes 1..3
        for (int m = 1; m < 4; m++) begin
            modeBits = m[1:0];
            cpol = modeBits[1];
            cpha = modeBits[0];
            spi_sclk = cpol;
            mmioWrite(5'd3, {30'd0, cpha, cpol});
            mmioRead(5'd3, rdVal); checkOutput("mode_ctrl", rdVal, {30'd0, cpha, cpol});
            mmioWrite(5'd1, 32'h81);
            ssLow();
            applyStimulus(8'h7E, 8, cpol, cpha, 1'b0, rxA);
            ssHigh();
            checkOutput("mode_miso_byte", 32'(rxA), 32'h81);
            mmioRead(5'd0, rdVal); checkOutput("mode_status", rdVal, 32'h57E);
            mmioWrite(5'd2, 32'h1);
        end
        spi_sclk = 1'b0;
        mmioWrite(5'd3, 32'h0);
        repeat (8) @(negedge clk);

        // Two-byte frame, second byte without TX refill and without pop
        mmioWrite(5'd1, 32'h96);
        ssLow();
        applyStimulus(8'h11, 8, 1'b0, 1'b0, 1'b0, rxA);
        applyStimulus(8'h22, 8, 1'b0, 1'b0, 1'b0, rxB);
        ssHigh();
        checkOutput("two_byte_first_miso", 32'(rxA), 32'h96);
        checkOutput("two_byte_idle_miso", 32'(rxB), 32'hFF);
        mmioRead(5'd0, rdVal); checkOutput("two_byte_overrun_status", rdVal, 32'h711);
`ifdef SPI_SLV_OVR_CNT_EN
        mmioRead(5'd4, rdVal); checkOutput("overrun_count", rdVal, 32'h1);
`else
        mmioRead(5'd4, rdVal); checkOutput("reg4_disabled", rdVal, 32'h0);
`endif
        mmioWrite(5'd2, 32'h3);
        mmioRead(5'd0, rdVal); checkOutput("clear_both", rdVal, 32'h411);

        // Aborted frame after 5 bits, then a clean frame
        mmioWrite(5'd1, 32'h3C);
        ssLow();
        applyStimulus(8'hF0, 5, 1'b0, 1'b0, 1'b0, rxA);
        ssHigh();
        mmioRead(5'd0, rdVal); checkOutput("abort_status", rdVal, 32'h411);
        checkOutput("abort_oe", 32'(spi_miso_oe), 32'h0);
        mmioWrite(5'd1, 32'h3C);
        ssLow();
        applyStimulus(8'h5A, 8, 1'b0, 1'b0, 1'b0, rxA);
        ssHigh();
        checkOutput("after_abort_miso", 32'(rxA), 32'h3C);
        mmioRead(5'd0, rdVal); checkOutput("after_abort_status", rdVal, 32'h55A);

        // Pop on the exact byte-complete cycle
        mmioWrite(5'd1, 32'h24);
        ssLow();
        applyStimulus(8'hC3, 8, 1'b0, 1'b0, 1'b1, rxA);
        ssHigh();
        checkOutput("pop_same_cycle_miso", 32'(rxA), 32'h24);
        mmioRead(5'd0, rdVal); checkOutput("pop_same_cycle_status", rdVal, 32'h5C3);
        mmioWrite(5'd2, 32'h1);

        // Reset pulsed mid-byte with ss_n held low
        ssLow();
        applyStimulus(8'hAA, 4, 1'b0, 1'b0, 1'b0, rxA);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        mmioRead(5'd0, rdVal); checkOutput("midreset_status", rdVal, 32'h400);
        checkOutput("midreset_oe", 32'(spi_miso_oe), 32'h0);
        applyStimulus(8'h0F, 4, 1'b0, 1'b0, 1'b0, rxA);
        checkOutput("midreset_stays_idle", 32'(spi_miso_oe), 32'h0);
        ssHigh();
        mmioWrite(5'd1, 32'hE7);
        ssLow();
        applyStimulus(8'h42, 8, 1'b0, 1'b0, 1'b0, rxA);
        ssHigh();
        checkOutput("post_reset_miso", 32'(rxA), 32'hE7);
        mmioRead(5'd0, rdVal); checkOutput("post_reset_status", rdVal, 32'h542);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
